// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings and access-size constants for mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {NONE, FETCH, DATA} owner_t;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: fixed data priority with a starvation counter that forces a fetch win
// after STARVE_LIMIT consecutive data wins over a pending fetch.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_req,
    input  logic d_req,
    input  logic pick_en,
    output logic grant_fetch,
    output logic grant_data
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve_cnt;
    logic          w_starved;
    assign w_starved   = r_starve_cnt == CW'(STARVE_LIMIT);
    assign grant_fetch = pick_en & i_req & (~d_req | w_starved);
    assign grant_data  = pick_en & d_req & ~(i_req & w_starved);
    // only data wins that actually bypass a waiting fetch count toward starvation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_starve_cnt <= '0;
        else if (grant_fetch)
            r_starve_cnt <= '0;
        else if (grant_data & i_req)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports,
// one outstanding transaction, back-to-back issue on the response cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_rw,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);
    state_t r_state, w_next;
    owner_t r_owner;
    logic   w_done, w_pick_en, w_grant_fetch, w_grant_data, w_pick;
    assign w_done    = (r_state == WAIT) & m_rvalid;
    assign w_pick_en = (r_state == IDLE) | w_done;
    assign w_pick    = w_grant_fetch | w_grant_data;
    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_req       (i_req),
        .d_req       (d_req),
        .pick_en     (w_pick_en),
        .grant_fetch (w_grant_fetch),
        .grant_data  (w_grant_data)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_pick ? REQ : IDLE;
            REQ:     w_next = m_gnt ? WAIT : REQ;
            WAIT:    w_next = m_rvalid ? (w_pick ? REQ : IDLE) : WAIT;
            default: w_next = IDLE;
        endcase
    end
    // request fields are latched at the pick so they stay stable through REQ
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= NONE;
            m_rw    <= 1'b0;
            m_size  <= SIZE_BYTE;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (w_pick) begin
            r_owner <= w_grant_data ? DATA : FETCH;
            m_rw    <= w_grant_data & d_rw;
            m_size  <= w_grant_data ? d_size : SIZE_WORD;
            m_addr  <= w_grant_data ? d_addr : i_addr;
            m_wdata <= w_grant_data ? d_wdata : '0;
        end else if (w_done) begin
            r_owner <= NONE;
        end
    end
    always_comb begin
        m_req    = r_state == REQ;
        busy     = r_state != IDLE;
        i_gnt    = (r_state == REQ) & m_gnt & (r_owner == FETCH);
        d_gnt    = (r_state == REQ) & m_gnt & (r_owner == DATA);
        i_rvalid = w_done & (r_owner == FETCH);
        d_rvalid = w_done & (r_owner == DATA);
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port backing memory between the fetch port (instruction reads) and the data port (loads and stores).
- Sits between the pipeline's fetch/memory stages and a unified memory model with req/gnt/rvalid handshakes.
- Allows one outstanding transaction at a time.
- Data has fixed priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_LIMIT, 4, consecutive data wins over a pending fetch before fetch is forced to win (≥1)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch request accepted by memory (1-cycle pulse)
i_rvalid  out  1  fetch read data valid (1-cycle pulse)
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request; held with d_rw/d_size/d_addr/d_wdata until d_gnt
d_rw  in  1  1 = write, 0 = read
d_size  in  2  0 byte, 1 half, 2 word
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  data response (read data or write ack)
d_rdata  out  DATA_W  load data
m_req  out  1  memory request
m_rw  out  1  memory read/write
m_size  out  2  memory access size
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_gnt  in  1  memory accepts m_req this cycle
m_rvalid  in  1  memory response valid; never earlier than the cycle after m_gnt
m_rdata  in  DATA_W  memory read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - m_req=0, m_rw=0, m_size=0, m_addr=0, m_wdata=0, busy=0.
  - All gnt/rvalid outputs are 0.
  - A memory response arriving after reset deasserts is ignored.
- States:
  - IDLE: no transaction.
  - REQ: m_req=1, waiting for m_gnt.
  - WAIT: accepted, waiting for m_rvalid.
- Arbitration occurs in IDLE, or in WAIT in the cycle m_rvalid=1. Picking rules:
  - Only d_req → data.
  - Only i_req → fetch.
  - Both, starve_cnt<STARVE_LIMIT → data, and starve_cnt++.
  - Both, starve_cnt==STARVE_LIMIT → fetch.
  - Any fetch win → starve_cnt=0.
  - Data win with i_req=0 → starve_cnt unchanged.
- Issue:
  - On a pick, m_* are registered from the winner; next state is REQ.
  - Fetch issues m_rw=0, m_size=2, m_wdata=0.
  - m_* are stable for the whole of REQ, regardless of requester inputs.
- REQ: when m_gnt=1 → x_gnt=1 for the owner (combinational, = m_req & m_gnt & owner), m_req drops next edge, state→WAIT.
- WAIT:
  - When m_rvalid=1 → x_rvalid=1 for the owner, and x_rdata=m_rdata (combinational).
  - Same cycle: if any request is pending, arbitrate and go to REQ (back-to-back, no bubble); otherwise go to IDLE and clear owner.
- Idle outputs: i_rdata/d_rdata show m_rdata at all times; only rvalid qualifies them.
- Minimum latency: req seen at edge N → m_req high after edge N; gnt at earliest in that cycle; rvalid at earliest one cycle later.
- Ignored inputs: m_rvalid outside WAIT; m_gnt outside REQ.
- Requester protocol: a request dropped before gnt is a protocol violation. The arbiter still completes the latched transaction and pulses gnt/rvalid as normal.
- Stores: writes complete only on m_rvalid. d_rvalid for a write is an ack; d_rdata is don't-care.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum {IDLE, REQ, WAIT};
  - the owner encoding {NONE, FETCH, DATA};
  - access-size constants SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
- Sub-module mem_arb_pick: pick logic plus starve_cnt register, with inputs i_req, d_req and a pick-enable strobe, and outputs grant_fetch and grant_data.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x01000000, m_gnt on first REQ cycle, rvalid 2 cycles later with m_rdata=0x00000013 → m_size=2, m_rw=0, i_gnt one pulse, i_rvalid one pulse with i_rdata=0x13, busy back to 0.
2. Store then load, with d_rw=1, d_size=0, d_addr=0x01000100, d_wdata=0xAB:
   - Response: m_rw=1, m_size=0, m_wdata=0xAB, d_rvalid ack.
   - Follow-up read of the same address returns 0xAB.
3. Contention and starvation, with i_req and d_req held high (d_req re-asserted each time) and STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I. The back-to-back issue shows no IDLE cycle between transactions.
4. Memory stall: m_gnt held low 5 cycles while i_addr/d_req toggle → m_addr/m_size/m_rw unchanged through REQ; gnt only when m_gnt rises.
5. Reset mid-WAIT: reset_n low for 1 cycle while a load is outstanding, then m_rvalid=1 → outputs 0 immediately, no d_rvalid pulse, state IDLE, starve_cnt=0.
6. Spurious response: m_rvalid=1 while IDLE → no rvalid pulse on either port, state stays IDLE.
